// File: rtl/mk_bsv_top_pkg.sv
// mk_bsv_top_pkg: shared FSM states, header fields and default timing constants.
package mk_bsv_top_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_CS_SETUP, ST_WAIT_BYTE, ST_SHIFT, ST_CS_HOLD} state_e;
   localparam int HDR_DEV      = 7;
   localparam int HDR_LEN_W    = 4;
   localparam int CS_GUARD     = 8;
   localparam int DEF_BAUD_DIV = 417;
   localparam int DEF_SPI_HALF = 4;
   localparam int DEF_TIMEOUT  = 1048576;
endpackage

// File: rtl/mk_bsv_top_uart_rx_tx.sv
// mk_bsv_top_uart_rx_tx: 8N1 UART receiver, 4-entry TX FIFO and gapless 8N1 transmitter.
module mk_bsv_top_uart_rx_tx
   import mk_bsv_top_pkg::*;
#(
   parameter int BAUD_DIV = DEF_BAUD_DIV
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd_i,
   output logic       txd_o,
   output logic       rx_valid_o,
   output logic [7:0] rx_data_o,
   output logic       rx_ferr_o,
   input  logic       push_i,
   input  logic [7:0] push_data_i,
   output logic       push_drop_o
);
   localparam int CW = $clog2(BAUD_DIV + 1);
   logic [1:0]    sync_q;
   logic          prev_q, rx_busy_q, rx_valid_q, rx_ferr_q;
   logic [CW-1:0] rx_cnt_q, tx_cnt_q;
   logic [3:0]    rx_bit_q, tx_bit_q;
   logic [7:0]    rx_sh_q;
   logic [7:0]    mem_q [4];
   logic [1:0]    wp_q, rp_q;
   logic [2:0]    cnt_q;
   logic          tx_busy_q, pop, push_ok;
   logic [9:0]    tx_sh_q;

   assign rx_valid_o  = rx_valid_q;
   assign rx_ferr_o   = rx_ferr_q;
   assign rx_data_o   = rx_sh_q;
   assign pop         = cnt_q != 3'd0 && (!tx_busy_q || (tx_cnt_q == '0 && tx_bit_q == 4'd9));
   assign push_ok     = push_i && (cnt_q != 3'd4 || pop);
   assign push_drop_o = push_i && cnt_q == 3'd4 && !pop;
   assign txd_o       = !tx_busy_q || tx_sh_q[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= 2'b11;
         prev_q     <= 1'b1;
         rx_busy_q  <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
      end else begin
         sync_q     <= {sync_q[0], rxd_i};
         prev_q     <= sync_q[1];
         rx_valid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
         if (!rx_busy_q) begin
            if (prev_q && !sync_q[1]) begin
               rx_busy_q <= 1'b1;
               rx_cnt_q  <= CW'(BAUD_DIV / 2 - 1);
               rx_bit_q  <= '0;
            end
         end else if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
         end else begin
            rx_cnt_q <= CW'(BAUD_DIV - 1);
            rx_bit_q <= rx_bit_q + 1'b1;
            if (rx_bit_q == 4'd0 && sync_q[1]) begin
               rx_busy_q <= 1'b0;
            end else if (rx_bit_q == 4'd9) begin
               rx_busy_q  <= 1'b0;
               rx_valid_q <= sync_q[1];
               rx_ferr_q  <= !sync_q[1];
            end else if (rx_bit_q != 4'd0) begin
               rx_sh_q <= {sync_q[1], rx_sh_q[7:1]};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wp_q] <= push_data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q      <= '0;
         rp_q      <= '0;
         cnt_q     <= '0;
         tx_busy_q <= 1'b0;
         tx_cnt_q  <= '0;
         tx_bit_q  <= '0;
         tx_sh_q   <= '1;
      end else begin
         wp_q  <= wp_q + {1'b0, push_ok};
         rp_q  <= rp_q + {1'b0, pop};
         cnt_q <= cnt_q + {2'b0, push_ok} - {2'b0, pop};
         if (pop) begin
            tx_busy_q <= 1'b1;
            tx_sh_q   <= {1'b1, mem_q[rp_q], 1'b0};
            tx_cnt_q  <= CW'(BAUD_DIV - 1);
            tx_bit_q  <= '0;
         end else if (tx_busy_q) begin
            if (tx_cnt_q != '0) begin
               tx_cnt_q <= tx_cnt_q - 1'b1;
            end else if (tx_bit_q == 4'd9) begin
               tx_busy_q <= 1'b0;
            end else begin
               tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
               tx_bit_q <= tx_bit_q + 1'b1;
               tx_cnt_q <= CW'(BAUD_DIV - 1);
            end
         end
      end
   end
endmodule

// File: rtl/mk_bsv_top.sv
// mk_bsv_top: UART-to-SPI bridge; a header byte picks LoRa/FRAM and length, MISO bytes echo on UART TX.
module mk_bsv_top
   import mk_bsv_top_pkg::*;
#(
   parameter int BAUD_DIV = DEF_BAUD_DIV,
   parameter int SPI_HALF = DEF_SPI_HALF,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic CLK,
   input  logic RST_N,
   output logic lora_sclk,
   output logic lora_mosi,
   output logic lora_cs,
   input  logic lora_miso,
   output logic fram_sclk,
   output logic fram_mosi,
   output logic fram_cs,
   input  logic fram_miso,
   output logic serial_txd,
   input  logic serial_rxd,
   output logic blue,
   output logic green,
   output logic red
);
   localparam int PW = $clog2(SPI_HALF + 1);
   localparam int TW = $clog2((TIMEOUT > CS_GUARD ? TIMEOUT : CS_GUARD) + 1);
   state_e                state_q, state_d;
   logic                  dev_q, dev_d, sclk_q, sclk_d, push_q, push_d, hold_v_q, hold_v_d, err_q, err_d;
   logic [HDR_LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
   logic [TW-1:0]         tmr_q, tmr_d;
   logic [3:0]            half_q, half_d;
   logic [PW-1:0]         ph_q, ph_d;
   logic [7:0]            sh_q, sh_d, mi_q, mi_d, hold_q, hold_d, rx_data, byte_in;
   logic                  rx_valid, rx_ferr, push_drop, take, ovr, cs_on, mosi, miso;

   mk_bsv_top_uart_rx_tx #(.BAUD_DIV(BAUD_DIV)) u_uart (
      .clk(CLK), .rst_n(RST_N), .rxd_i(serial_rxd), .txd_o(serial_txd),
      .rx_valid_o(rx_valid), .rx_data_o(rx_data), .rx_ferr_o(rx_ferr),
      .push_i(push_q), .push_data_i(mi_q), .push_drop_o(push_drop)
   );

   assign take      = (state_q == ST_IDLE || state_q == ST_WAIT_BYTE) && (hold_v_q || rx_valid);
   assign byte_in   = hold_v_q ? hold_q : rx_data;
   assign miso      = dev_q ? fram_miso : lora_miso;
   assign cs_on     = state_q != ST_IDLE;
   assign mosi      = state_q == ST_SHIFT && sh_q[7];
   assign lora_cs   = !(cs_on && !dev_q);
   assign fram_cs   = !(cs_on && dev_q);
   assign lora_sclk = sclk_q && !dev_q;
   assign fram_sclk = sclk_q && dev_q;
   assign lora_mosi = mosi && !dev_q;
   assign fram_mosi = mosi && dev_q;
   assign blue      = lora_cs;
   assign green     = fram_cs;
   assign red       = !err_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         dev_q    <= 1'b0;
         len_q    <= '0;
         idx_q    <= '0;
         tmr_q    <= '0;
         half_q   <= '0;
         ph_q     <= '0;
         sclk_q   <= 1'b0;
         sh_q     <= '0;
         mi_q     <= '0;
         push_q   <= 1'b0;
         hold_v_q <= 1'b0;
         hold_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         dev_q    <= dev_d;
         len_q    <= len_d;
         idx_q    <= idx_d;
         tmr_q    <= tmr_d;
         half_q   <= half_d;
         ph_q     <= ph_d;
         sclk_q   <= sclk_d;
         sh_q     <= sh_d;
         mi_q     <= mi_d;
         push_q   <= push_d;
         hold_v_q <= hold_v_d;
         hold_q   <= hold_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      dev_d    = dev_q;
      len_d    = len_q;
      idx_d    = idx_q;
      tmr_d    = tmr_q + 1'b1;
      half_d   = half_q;
      ph_d     = ph_q;
      sclk_d   = sclk_q;
      sh_d     = sh_q;
      mi_d     = mi_q;
      push_d   = 1'b0;
      hold_v_d = hold_v_q && !take;
      hold_d   = hold_q;
      err_d    = err_q;
      ovr      = 1'b0;
      // bytes not consumed this cycle wait in the holding register
      if (rx_valid && !(take && !hold_v_q)) begin
         ovr      = hold_v_d;
         hold_v_d = 1'b1;
         hold_d   = hold_v_d && ovr ? hold_q : rx_data;
      end
      case (state_q)
         ST_IDLE: if (take && byte_in[HDR_LEN_W-1:0] != '0) begin
            state_d = ST_CS_SETUP;
            dev_d   = byte_in[HDR_DEV];
            len_d   = byte_in[HDR_LEN_W-1:0];
            idx_d   = '0;
            tmr_d   = '0;
            err_d   = 1'b0;
         end
         ST_CS_SETUP: if (tmr_q == TW'(CS_GUARD - 1)) begin
            state_d = ST_WAIT_BYTE;
            tmr_d   = '0;
         end
         ST_WAIT_BYTE: if (take) begin
            state_d = ST_SHIFT;
            sh_d    = byte_in;
            half_d  = '0;
            ph_d    = '0;
            tmr_d   = '0;
         end else if (tmr_q == TW'(TIMEOUT - 1)) begin
            state_d = ST_CS_HOLD;
            tmr_d   = '0;
            err_d   = 1'b1;
         end
         ST_SHIFT: begin
            ph_d = ph_q + 1'b1;
            if (ph_q == PW'(SPI_HALF - 1)) begin
               ph_d   = '0;
               half_d = half_q + 1'b1;
               sclk_d = !half_q[0];
               if (!half_q[0]) begin
                  mi_d   = {mi_q[6:0], miso};
                  push_d = half_q == 4'd14;
               end else begin
                  sh_d = {sh_q[6:0], 1'b0};
                  if (half_q == 4'd15) begin
                     idx_d   = idx_q + 1'b1;
                     tmr_d   = '0;
                     state_d = idx_d == len_q ? ST_CS_HOLD : ST_WAIT_BYTE;
                  end
               end
            end
         end
         ST_CS_HOLD: if (tmr_q == TW'(CS_GUARD - 1)) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (rx_ferr) begin
         state_d = ST_IDLE;
         sclk_d  = 1'b0;
      end
      if (rx_ferr || push_drop || ovr) err_d = 1'b1;
   end
endmodule

// File: tb/tb_mk_bsv_top.sv
// tb_mk_bsv_top: directed scenario tasks for the UART-to-SPI bridge with SPI slave models and a UART TX monitor.
module tb_mk_bsv_top;
   localparam int BD = 16;
   localparam int TO = 3000;
   logic clk = 1'b0;
   logic RST_N = 1'b0;
   logic serial_rxd = 1'b1;
   logic fram_miso = 1'b0;
   logic lora_miso;
   logic lora_sclk, lora_mosi, lora_cs, fram_sclk, fram_mosi, fram_cs, serial_txd, blue, green, red;
   int passed = 0, total = 0;
   int lp = 0, fp = 0, csf = 0;
   logic [31:0] lm = '0, fm = '0;
   logic [7:0] txq[$];
   logic [7:0] lmiso [2];
   logic [2:0] lbit = '0;
   logic [1:0] lbyte = '0;

   mk_bsv_top #(.BAUD_DIV(BD), .SPI_HALF(4), .TIMEOUT(TO)) dut (
      .CLK(clk), .RST_N(RST_N),
      .lora_sclk(lora_sclk), .lora_mosi(lora_mosi), .lora_cs(lora_cs), .lora_miso(lora_miso),
      .fram_sclk(fram_sclk), .fram_mosi(fram_mosi), .fram_cs(fram_cs), .fram_miso(fram_miso),
      .serial_txd(serial_txd), .serial_rxd(serial_rxd),
      .blue(blue), .green(green), .red(red)
   );

   always #5 clk = ~clk;

   always @(posedge lora_sclk) begin lp++; lm = {lm[30:0], lora_mosi}; end
   always @(posedge fram_sclk) begin fp++; fm = {fm[30:0], fram_mosi}; end
   always @(negedge lora_cs or negedge fram_cs) csf++;

   always @(negedge lora_sclk or posedge lora_cs) begin
      if (lora_cs === 1'b1) begin lbit = '0; lbyte = '0; end
      else if (lbit == 3'd7) begin lbit = '0; lbyte = lbyte + 2'd1; end
      else lbit = lbit + 3'd1;
   end
   assign lora_miso = (lbyte < 2'd2) ? lmiso[lbyte[0]][3'd7 - lbit] : 1'b0;

   initial begin
      logic [7:0] b;
      forever begin
         @(negedge serial_txd);
         repeat (BD / 2) @(negedge clk);
         if (serial_txd === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
               repeat (BD) @(negedge clk);
               b[i] = serial_txd;
            end
            repeat (BD) @(negedge clk);
            txq.push_back(b);
         end
      end
   end

   task automatic uart_send(input logic [7:0] d, input logic stop);
      serial_rxd = 1'b0;
      repeat (BD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         serial_rxd = d[i];
         repeat (BD) @(negedge clk);
      end
      serial_rxd = stop;
      repeat (BD) @(negedge clk);
      serial_rxd = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic clear_mon();
      lp = 0; fp = 0; csf = 0; lm = '0; fm = '0;
      txq.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++; if ({lora_sclk, lora_mosi, lora_cs, fram_sclk, fram_mosi, fram_cs} !== 6'b001001)
         $display("FAIL reset_spi got=%b exp=001001", {lora_sclk, lora_mosi, lora_cs, fram_sclk, fram_mosi, fram_cs}); else passed++;
      total++; if (serial_txd !== 1'b1) $display("FAIL reset_txd got=%b exp=1", serial_txd); else passed++;
      total++; if ({blue, green, red} !== 3'b111) $display("FAIL reset_leds got=%b exp=111", {blue, green, red}); else passed++;
      RST_N = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_lora_two();
      int n;
      logic [15:0] got;
      clear_mon();
      lmiso[0] = 8'h00; lmiso[1] = 8'h7F;
      uart_send(8'h02, 1'b1);
      total++; if (lora_cs !== 1'b0) $display("FAIL lora2_cs_low got=%b exp=0", lora_cs); else passed++;
      total++; if (blue !== 1'b0) $display("FAIL lora2_blue_lit got=%b exp=0", blue); else passed++;
      total++; if ({fram_cs, green} !== 2'b11) $display("FAIL lora2_fram_idle got=%b exp=11", {fram_cs, green}); else passed++;
      uart_send(8'h9F, 1'b1);
      uart_send(8'h00, 1'b1);
      n = 0; while (lora_cs !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      n = 0; while (txq.size() < 2 && n < 2000) begin @(negedge clk); n++; end
      total++; if (lp !== 16) $display("FAIL lora2_pulses got=%0d exp=16", lp); else passed++;
      total++; if (lm[15:0] !== 16'h9F00) $display("FAIL lora2_mosi got=%h exp=9f00", lm[15:0]); else passed++;
      total++; if (fp !== 0 || csf !== 1) $display("FAIL lora2_fram_quiet got fp=%0d csf=%0d exp fp=0 csf=1", fp, csf); else passed++;
      got = (txq.size() == 2) ? {txq[0], txq[1]} : 16'hxxxx;
      total++; if (got !== 16'h007F) $display("FAIL lora2_tx got=%h exp=007f", got); else passed++;
      total++; if ({lora_cs, blue, red} !== 3'b111) $display("FAIL lora2_end got=%b exp=111", {lora_cs, blue, red}); else passed++;
      repeat (50) @(negedge clk);
   endtask

   task automatic test_fram_one();
      int n;
      logic [7:0] got;
      clear_mon();
      fram_miso = 1'b1;
      uart_send(8'h81, 1'b1);
      total++; if ({fram_cs, green, blue, lora_cs} !== 4'b0011) $display("FAIL fram1_cs got=%b exp=0011", {fram_cs, green, blue, lora_cs}); else passed++;
      uart_send(8'hA5, 1'b1);
      n = 0; while (fram_cs !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      n = 0; while (txq.size() < 1 && n < 1000) begin @(negedge clk); n++; end
      got = (txq.size() == 1) ? txq[0] : 8'hxx;
      total++; if (fp !== 8) $display("FAIL fram1_pulses got=%0d exp=8", fp); else passed++;
      total++; if (fm[7:0] !== 8'hA5) $display("FAIL fram1_mosi got=%h exp=a5", fm[7:0]); else passed++;
      total++; if (got !== 8'hFF) $display("FAIL fram1_tx got=%h exp=ff", got); else passed++;
      total++; if (lp !== 0) $display("FAIL fram1_lora_quiet got=%0d exp=0", lp); else passed++;
      total++; if ({green, blue} !== 2'b11) $display("FAIL fram1_end_leds got=%b exp=11", {green, blue}); else passed++;
      repeat (50) @(negedge clk);
   endtask

   task automatic test_zero_len();
      clear_mon();
      uart_send(8'h00, 1'b1);
      repeat (300) @(negedge clk);
      total++; if (csf !== 0) $display("FAIL zero_cs_falls got=%0d exp=0", csf); else passed++;
      total++; if (lp + fp !== 0) $display("FAIL zero_pulses got=%0d exp=0", lp + fp); else passed++;
      total++; if (txq.size() !== 0) $display("FAIL zero_tx got=%0d bytes exp=0", txq.size()); else passed++;
      total++; if (red !== 1'b1) $display("FAIL zero_red got=%b exp=1", red); else passed++;
   endtask

   task automatic test_timeout();
      int n;
      clear_mon();
      fram_miso = 1'b0;
      uart_send(8'h83, 1'b1);
      uart_send(8'h3C, 1'b1);
      n = 0; while (fram_cs !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
      total++; if (n < 2950 || n > 3200) $display("FAIL to_delay got=%0d cycles exp=about 3064", n); else passed++;
      total++; if (red !== 1'b0) $display("FAIL to_red got=%b exp=0", red); else passed++;
      total++; if (fp !== 8 || fm[7:0] !== 8'h3C) $display("FAIL to_shift got pulses=%0d mosi=%h exp 8 3c", fp, fm[7:0]); else passed++;
      repeat (400) @(negedge clk);
      clear_mon();
      lmiso[0] = 8'hC3;
      uart_send(8'h01, 1'b1);
      total++; if (red !== 1'b1) $display("FAIL to_red_clear got=%b exp=1", red); else passed++;
      uart_send(8'h5A, 1'b1);
      n = 0; while (lora_cs !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      n = 0; while (txq.size() < 1 && n < 1000) begin @(negedge clk); n++; end
      total++; if (lm[7:0] !== 8'h5A || lp !== 8) $display("FAIL to_next_mosi got=%h/%0d exp=5a/8", lm[7:0], lp); else passed++;
      total++; if (txq.size() < 1 || txq[0] !== 8'hC3) $display("FAIL to_next_tx got=%0d bytes exp=c3", txq.size()); else passed++;
      repeat (50) @(negedge clk);
   endtask

   task automatic test_framing();
      int n;
      clear_mon();
      fram_miso = 1'b1;
      uart_send(8'h82, 1'b1);
      uart_send(8'h11, 1'b1);
      uart_send(8'h55, 1'b0);
      n = 0; while (fram_cs !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      total++; if (fram_cs !== 1'b1) $display("FAIL ferr_cs got=%b exp=1", fram_cs); else passed++;
      total++; if (red !== 1'b0) $display("FAIL ferr_red got=%b exp=0", red); else passed++;
      total++; if (fp !== 8) $display("FAIL ferr_pulses got=%0d exp=8", fp); else passed++;
      repeat (400) @(negedge clk);
   endtask

   task automatic test_reset_mid_shift();
      int n, held;
      clear_mon();
      uart_send(8'h01, 1'b1);
      uart_send(8'hFF, 1'b1);
      n = 0; while (lora_sclk !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      total++; if (lora_sclk !== 1'b1) $display("FAIL rst_mid_shifting got=%b exp=1", lora_sclk); else passed++;
      RST_N = 1'b0;
      #1;
      total++; if ({lora_cs, lora_sclk, fram_cs, fram_sclk} !== 4'b1010) $display("FAIL rst_mid_spi got=%b exp=1010", {lora_cs, lora_sclk, fram_cs, fram_sclk}); else passed++;
      total++; if ({serial_txd, blue, green, red} !== 4'b1111) $display("FAIL rst_mid_txd_leds got=%b exp=1111", {serial_txd, blue, green, red}); else passed++;
      repeat (3) @(negedge clk);
      RST_N = 1'b1;
      held = lp;
      repeat (300) @(negedge clk);
      total++; if (lp !== held || lora_cs !== 1'b1) $display("FAIL rst_mid_after got pulses=%0d cs=%b exp pulses=%0d cs=1", lp, lora_cs, held); else passed++;
   endtask

   initial begin
      test_reset();
      test_lora_two();
      test_fram_one();
      test_zero_len();
      test_timeout();
      test_framing();
      test_reset_mid_shift();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
